// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_unit_pkg
// Brief   : Shared widths, NOP constant and fetch entry type for the IF stage.
// Revision: 1.0 - initial release
// ============================================================================
package if_fetch_unit_pkg;

  localparam int c_ADDR_W  = 12;
  localparam int c_INSTR_W = 19;

  localparam logic [c_INSTR_W-1:0] c_NOP = '0;

  typedef struct packed {
    logic [c_INSTR_W-1:0] instr;
    logic [c_ADDR_W-1:0]  pc_plus1;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_unit_if
// Brief   : Instruction-memory request/response bus (master = fetch unit).
// Revision: 1.0 - initial release
// ============================================================================
interface if_fetch_unit_if
  import if_fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = c_ADDR_W,
  parameter int INSTR_W = c_INSTR_W
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/if_fetch_unit_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fetch_fifo
// Brief   : 2-entry synchronous FIFO with flush for buffered fetch responses.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter type ENTRY_T = fetch_entry_t
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_flush,
  input  wire logic       i_push,
  input  wire logic       i_pop,
  input  wire ENTRY_T     i_data,
  output ENTRY_T          o_data,
  output logic            o_empty,
  output logic [1:0]      o_count
);

  ENTRY_T     r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = i_push && (r_count != 2'd2);
  assign w_do_pop  = i_pop  && (r_count != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_unit
// Brief   : Instruction-fetch stage: PC, memory requests, hold register,
//           stall/redirect handling. FETCH_BUF_EN adds a 2-entry response FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = c_ADDR_W,
  parameter int                INSTR_W  = c_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               stall,
  input  wire logic               br_taken,
  input  wire logic [ADDR_W-1:0]  br_target,
  if_fetch_unit_if.master         imem,
  output logic [INSTR_W-1:0]      PR0_instruction,
  output logic [ADDR_W-1:0]       PR0_PC_plus1,
  output logic                    fetch_valid
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus1;
  } entry_t;

`ifdef FETCH_BUF_EN
  localparam logic [2:0] c_OUT_LIMIT = 3'd2;
`else
  localparam logic [2:0] c_OUT_LIMIT = 3'd1;
`endif

  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        r_out_cnt;
  logic [1:0]        r_drop_cnt;
  logic              r_hold_valid;
  entry_t            r_hold;

  logic       w_req;
  logic       w_accept;
  logic       w_rvalid;
  logic       w_resp_live;
  logic       w_hold_load;
  logic [1:0] w_live_cnt;
  logic [1:0] w_fifo_count;
  entry_t     w_resp_entry;
  entry_t     w_next_entry;
  logic       w_next_valid;

  // Responses with nothing outstanding (e.g. straddling reset) are ignored.
  assign w_rvalid    = imem.imem_rvalid && (r_out_cnt != 2'd0);
  assign w_resp_live = w_rvalid && !br_taken && (r_drop_cnt == 2'd0);
  assign w_hold_load = !stall || !r_hold_valid;

  // Oldest live request address is pc minus the non-dropped requests in flight.
  assign w_live_cnt            = r_out_cnt - r_drop_cnt;
  assign w_resp_entry.instr    = imem.imem_rdata;
  assign w_resp_entry.pc_plus1 = r_pc - ADDR_W'(w_live_cnt) + ADDR_W'(1);

`ifdef FETCH_BUF_EN
  entry_t w_fifo_dout;
  logic   w_fifo_empty;
  logic   w_fifo_push;
  logic   w_fifo_pop;

  assign w_fifo_pop  = w_hold_load && !w_fifo_empty && !br_taken;
  // An empty FIFO is bypassed so the response reaches the hold register directly.
  assign w_fifo_push = w_resp_live && !(w_hold_load && w_fifo_empty);

  fetch_fifo #(
    .ENTRY_T (entry_t)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (br_taken),
    .i_push  (w_fifo_push),
    .i_pop   (w_fifo_pop),
    .i_data  (w_resp_entry),
    .o_data  (w_fifo_dout),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_next_valid = 1'b0;
    w_next_entry = '0;
    if (!w_fifo_empty) begin
      w_next_valid = 1'b1;
      w_next_entry = w_fifo_dout;
    end else if (w_resp_live) begin
      w_next_valid = 1'b1;
      w_next_entry = w_resp_entry;
    end
  end
`else
  assign w_fifo_count = 2'd0;

  always_comb begin
    w_next_valid = 1'b0;
    w_next_entry = '0;
    if (w_resp_live) begin
      w_next_valid = 1'b1;
      w_next_entry = w_resp_entry;
    end
  end
`endif

  assign w_req = !rst && !stall && !br_taken &&
                 (({1'b0, r_out_cnt} + {1'b0, w_fifo_count}) < c_OUT_LIMIT);
  assign w_accept = w_req && imem.imem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_out_cnt  <= 2'd0;
      r_drop_cnt <= 2'd0;
    end else begin
      r_out_cnt <= r_out_cnt + {1'b0, w_accept} - {1'b0, w_rvalid};
      if (br_taken) begin
        r_pc       <= br_target;
        r_drop_cnt <= r_out_cnt - {1'b0, w_rvalid};
      end else begin
        if (w_accept) r_pc <= r_pc + ADDR_W'(1);
        if (w_rvalid && (r_drop_cnt != 2'd0)) r_drop_cnt <= r_drop_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold       <= '0;
    end else if (br_taken) begin
      r_hold_valid <= 1'b0;
      r_hold       <= '0;
    end else if (w_hold_load) begin
      r_hold_valid <= w_next_valid;
      r_hold       <= w_next_entry;
    end
  end

  assign imem.imem_req   = w_req;
  assign imem.imem_addr  = r_pc;
  assign PR0_instruction = r_hold_valid ? r_hold.instr : INSTR_W'(c_NOP);
  assign PR0_PC_plus1    = r_hold.pc_plus1;
  assign fetch_valid     = r_hold_valid;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_fetch_unit
// Brief   : Directed self-checking bench for if_fetch_unit with a latency-
//           configurable in-order memory model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        stall    = 1'b0;
  logic        br_taken = 1'b0;
  logic [11:0] br_target = '0;
  logic [18:0] PR0_instruction;
  logic [11:0] PR0_PC_plus1;
  logic        fetch_valid;

  int n_tests = 0;
  int n_fail  = 0;

  if_fetch_unit_if #(.ADDR_W(12), .INSTR_W(19)) bus ();

  if_fetch_unit #(.ADDR_W(12), .INSTR_W(19), .RESET_PC(12'h000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .imem            (bus),
    .PR0_instruction (PR0_instruction),
    .PR0_PC_plus1    (PR0_PC_plus1),
    .fetch_valid     (fetch_valid)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [18:0] mem_of(input logic [11:0] a);
    case (a)
      12'h000: mem_of = 19'h00011;
      12'h001: mem_of = 19'h00022;
      12'h002: mem_of = 19'h00033;
      12'h003: mem_of = 19'h00044;
      default: mem_of = {7'h2A, a};
    endcase
  endfunction

  // Memory model: fixed latency of lat_idx+1 cycles, in order.
  logic [1:0]  lat_idx = 2'd0;
  logic [3:0]  pv;
  logic [18:0] pd [4];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[2:0], bus.imem_req && bus.imem_ready};
      pd[0] <= mem_of(bus.imem_addr);
      for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
    end
  end

  always_comb begin
    bus.imem_rvalid = pv[lat_idx];
    bus.imem_rdata  = pd[lat_idx];
  end

  initial bus.imem_ready = 1'b1;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output logic [18:0] ins,
                            output logic [11:0] pc1, output bit ok);
    int n = 0;
    ok = 1'b0; ins = '0; pc1 = '0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (fetch_valid === 1'b1) begin
        ok = 1'b1; ins = PR0_instruction; pc1 = PR0_PC_plus1;
      end
    end
  endtask

  task automatic test_reset();
    lat_idx = 2'd0;
    do_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    n_tests++; if (bus.imem_addr !== 12'h000) begin n_fail++; $display("FAIL reset_addr: got %h want 000", bus.imem_addr); end
    n_tests++; if (PR0_instruction !== 19'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", PR0_instruction); end
    n_tests++; if (PR0_PC_plus1 !== 12'h0) begin n_fail++; $display("FAIL reset_pc1: got %h want 0", PR0_PC_plus1); end
    n_tests++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", fetch_valid); end
  endtask

  task automatic test_run();
    logic [31:0] exp [8];
    int n;
`ifdef FETCH_BUF_EN
    n = 5;
    exp[0] = {1'b0, 19'h00000, 12'h000};
    exp[1] = {1'b1, 19'h00011, 12'h001};
    exp[2] = {1'b1, 19'h00022, 12'h002};
    exp[3] = {1'b1, 19'h00033, 12'h003};
    exp[4] = {1'b1, 19'h00044, 12'h004};
    exp[5] = '0; exp[6] = '0; exp[7] = '0;
`else
    n = 8;
    exp[0] = {1'b0, 19'h00000, 12'h000};
    exp[1] = {1'b1, 19'h00011, 12'h001};
    exp[2] = {1'b0, 19'h00000, 12'h000};
    exp[3] = {1'b1, 19'h00022, 12'h002};
    exp[4] = {1'b0, 19'h00000, 12'h000};
    exp[5] = {1'b1, 19'h00033, 12'h003};
    exp[6] = {1'b0, 19'h00000, 12'h000};
    exp[7] = {1'b1, 19'h00044, 12'h004};
`endif
    lat_idx = 2'd0;
    do_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_tests++;
      if ({fetch_valid, PR0_instruction, PR0_PC_plus1} !== exp[i]) begin
        n_fail++;
        $display("FAIL run_cycle%0d: got {v,instr,pc1}=%h want %h", i,
                 {fetch_valid, PR0_instruction, PR0_PC_plus1}, exp[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [18:0] ins; logic [11:0] pc1; bit ok;
    lat_idx = 2'd0;
    do_reset();
    wait_valid(10, ins, pc1, ok);
    n_tests++; if (!ok || ins !== 19'h00011) begin n_fail++; $display("FAIL stall_first: got %h seen=%0d want 00011", ins, ok); end
    wait_valid(10, ins, pc1, ok);
    n_tests++; if (!ok || ins !== 19'h00022 || pc1 !== 12'h002) begin n_fail++; $display("FAIL stall_pre: got %h/%h seen=%0d want 00022/002", ins, pc1, ok); end
    stall = 1'b1;
    #1;
    n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_now: got %b want 0", bus.imem_req); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({fetch_valid, PR0_instruction, PR0_PC_plus1, bus.imem_req} !== {1'b1, 19'h00022, 12'h002, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got v=%b instr=%h pc1=%h req=%b want 1/00022/002/0",
                 i, fetch_valid, PR0_instruction, PR0_PC_plus1, bus.imem_req);
      end
    end
    stall = 1'b0;
    wait_valid(10, ins, pc1, ok);
    n_tests++; if (!ok || ins !== 19'h00033 || pc1 !== 12'h003) begin n_fail++; $display("FAIL stall_after: got %h/%h seen=%0d want 00033/003", ins, pc1, ok); end
  endtask

  task automatic test_redirect_inflight();
    logic [18:0] ins; logic [11:0] pc1; bit ok;
    lat_idx = 2'd2;
    do_reset();
    repeat (2) @(negedge clk);
    br_taken = 1'b1; br_target = 12'h040;
    @(negedge clk);
    n_tests++; if (bus.imem_addr !== 12'h040 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL redir_addr: got addr=%h v=%b want 040/0", bus.imem_addr, fetch_valid); end
    br_taken = 1'b0;
    wait_valid(30, ins, pc1, ok);
    n_tests++; if (!ok || ins !== 19'h2A040 || pc1 !== 12'h041) begin n_fail++; $display("FAIL redir_first: got %h/%h seen=%0d want 2a040/041", ins, pc1, ok); end
    wait_valid(30, ins, pc1, ok);
    n_tests++; if (!ok || ins !== 19'h2A041 || pc1 !== 12'h042) begin n_fail++; $display("FAIL redir_second: got %h/%h seen=%0d want 2a041/042", ins, pc1, ok); end
  endtask

  task automatic test_redirect_stall();
    logic [18:0] ins; logic [11:0] pc1; bit ok;
    lat_idx = 2'd0;
    do_reset();
    wait_valid(10, ins, pc1, ok);
    wait_valid(10, ins, pc1, ok);
    n_tests++; if (!ok || ins !== 19'h00022) begin n_fail++; $display("FAIL rs_pre: got %h seen=%0d want 00022", ins, ok); end
    stall = 1'b1; br_taken = 1'b1; br_target = 12'h123;
    @(negedge clk);
    n_tests++;
    if ({fetch_valid, PR0_instruction, PR0_PC_plus1, bus.imem_addr} !== {1'b0, 19'h0, 12'h000, 12'h123}) begin
      n_fail++;
      $display("FAIL rs_nop: got v=%b instr=%h pc1=%h addr=%h want 0/0/000/123",
               fetch_valid, PR0_instruction, PR0_PC_plus1, bus.imem_addr);
    end
    br_taken = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.imem_req !== 1'b0 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rs_stalled: got req=%b v=%b want 0/0", bus.imem_req, fetch_valid); end
    stall = 1'b0;
    wait_valid(10, ins, pc1, ok);
    n_tests++; if (!ok || ins !== 19'h2A123 || pc1 !== 12'h124) begin n_fail++; $display("FAIL rs_target: got %h/%h seen=%0d want 2a123/124", ins, pc1, ok); end
  endtask

  task automatic test_backpressure();
    logic [18:0] ins; logic [11:0] pc1; bit ok;
    lat_idx = 2'd0;
    bus.imem_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.imem_req, bus.imem_addr, fetch_valid} !== {1'b1, 12'h000, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_cycle%0d: got req=%b addr=%h v=%b want 1/000/0",
                 i, bus.imem_req, bus.imem_addr, fetch_valid);
      end
    end
    bus.imem_ready = 1'b1;
    wait_valid(10, ins, pc1, ok);
    n_tests++; if (!ok || ins !== 19'h00011 || pc1 !== 12'h001) begin n_fail++; $display("FAIL bp_release: got %h/%h seen=%0d want 00011/001", ins, pc1, ok); end
  endtask

  task automatic test_wrap();
    logic [18:0] ins; logic [11:0] pc1; bit ok;
    lat_idx = 2'd0;
    do_reset();
    @(negedge clk);
    br_taken = 1'b1; br_target = 12'hFFF;
    @(negedge clk);
    br_taken = 1'b0;
    wait_valid(10, ins, pc1, ok);
    n_tests++; if (!ok || ins !== 19'h2AFFF || pc1 !== 12'h000) begin n_fail++; $display("FAIL wrap_top: got %h/%h seen=%0d want 2afff/000", ins, pc1, ok); end
    wait_valid(10, ins, pc1, ok);
    n_tests++; if (!ok || ins !== 19'h00011 || pc1 !== 12'h001) begin n_fail++; $display("FAIL wrap_zero: got %h/%h seen=%0d want 00011/001", ins, pc1, ok); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_run();
    test_stall();
    test_redirect_inflight();
    test_redirect_stall();
    test_backpressure();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
